uart_echo_responder: RTL and testbench
======================================

UART_ECHO_RESPONDER -- requirements
Module: uart_echo_responder

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clk cycles per serial bit; legal values are even integers of 4 or more.
REQ-002 Parameter ERR_WORD, default 32'hDEADBEEF: reply payload sent for a bad frame.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 rx  input  1  serial line from the initiator; idle high; asynchronous to clk.
REQ-006 parity_type  input  1  0 = odd parity, 1 = even parity.
REQ-007 tx_hold  input  1  while high, no new reply frame starts; a frame already in progress completes.
REQ-008 tx  output  1  serial reply line; idle high.
REQ-009 busy  output  1  high while a reply is transmitting or pending.
REQ-010 frame_count  output  16  count of good frames received; saturates at 16'hFFFF.
REQ-011 err_count  output  16  count of parity and framing errors; saturates at 16'hFFFF.
REQ-012 overrun_count  output  8  count of dropped replies; saturates at 8'hFF.

Function
REQ-013 Frame format, both directions, 35 bits: start bit 0, 32 data bits LSB first, parity bit, stop bit 1.
REQ-014 Parity bit: ^data when parity_type=1; ~^data when parity_type=0.
REQ-015 rx passes through a 2-flop synchronizer before any use; that 2-cycle delay is excluded from the latencies below.
REQ-016 RX FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-017 IDLE -> START on a synchronized high-to-low transition.
REQ-018 START samples at CLKS_PER_BIT/2 cycles:
  - low: go to DATA.
  - high: glitch; return to IDLE with no count change.
REQ-019 DATA, PARITY and STOP each sample once per CLKS_PER_BIT cycles, measured from the start-bit sample point.
REQ-020 RX latches parity_type at start-bit validation; later changes do not affect that frame.
REQ-021 At the stop-bit sample, one of three outcomes:
  - stop=1, parity correct: reply = received word; frame_count+1; go to IDLE.
  - stop=1, parity wrong: reply = ERR_WORD; err_count+1; go to IDLE.
  - stop=0: reply = ERR_WORD; err_count+1; go to WAIT_HIGH.
REQ-022 WAIT_HIGH -> IDLE on the first synchronized high sample.
REQ-023 A single-entry pending buffer holds one reply word.
REQ-024 When a reply is produced and the buffer is full, the new reply is dropped; overrun_count+1; the buffered word is retained.
REQ-025 TX FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-026 TX IDLE with buffer full and tx_hold=0 in the same cycle: load the shift register, free the buffer, latch parity_type.
REQ-027 After the TX load, tx drives the start bit from the next rising edge; each bit is held exactly CLKS_PER_BIT cycles.
REQ-028 Latency with TX idle and tx_hold=0: tx falls on the 2nd rising edge after the stop-bit sample edge.
REQ-029 A reply produced in the same cycle the buffer is loaded into TX is stored; it is not an overrun.
REQ-030 RX and TX run concurrently; receiving never stalls for transmission.
REQ-031 busy = (TX state != IDLE) OR buffer full, registered.

Reset
REQ-032 While rst is high: tx=1, busy=0, all counters 0, both FSMs IDLE, buffer empty, synchronizer flops 1.
REQ-033 rst asserted mid-frame aborts both directions immediately; tx is 1 asynchronously; no partial count update.
REQ-034 After rst deasserts, a line already low is not taken as a start bit until a high-to-low transition is seen.

Verification
REQ-035 parity_type=0, send A5A5A5A5 with parity bit 1 -> reply carries A5A5A5A5, parity 1, stop 1; frame_count=1; tx falls per REQ-028.
REQ-036 parity_type=1, send 12345678 with parity bit 1 -> reply echoes 12345678 with parity 1; err_count=0.
REQ-037 Send A5A5A5A5 with parity bit flipped -> reply DEADBEEF; err_count=1; frame_count unchanged.
REQ-038 Send a frame with stop bit 0 and hold rx low 5 bit times -> one DEADBEEF reply; err_count=1; no new frame until rx returns high.
REQ-039 tx_hold=1, send 3 good frames 11111111, 22222222, 33333333 -> busy=1, tx stays 1, overrun_count=2; release tx_hold -> only 11111111 is sent.
REQ-040 Assert rst mid-reply at data bit 10 -> tx=1 within the same cycle; busy=0; counters 0; the next good frame echoes normally.

Source files
------------

// File: rtl/uart_echo_responder.sv
// Serial echo responder: receives 35-bit frames (start, 32 data LSB first, parity, stop)
// and replies with the received word, or ERR_WORD when the frame is bad.
module uart_echo_responder #(
  parameter int          CLKS_PER_BIT = 16,
  parameter logic [31:0] ERR_WORD     = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic        parity_type,
  input  logic        tx_hold,
  output logic        tx,
  output logic        busy,
  output logic [15:0] frame_count,
  output logic [15:0] err_count,
  output logic [7:0]  overrun_count
);

  localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizer and start-edge detection
  // ---------------------------------------------------------------------------
  logic [1:0] sync_reg;
  logic [2:0] live_reg;
  logic       rx_prev_reg;
  logic       rx_s;
  logic       start_edge;

  assign rx_s = sync_reg[1];
  // live_reg marks which flops hold real line samples rather than reset values,
  // so a line that is already low when reset releases never looks like an edge.
  assign start_edge = live_reg[2] & rx_prev_reg & ~rx_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg    <= 2'b11;
      live_reg    <= 3'b000;
      rx_prev_reg <= 1'b1;
    end else begin
      sync_reg    <= {sync_reg[0], rx};
      live_reg    <= {live_reg[1:0], 1'b1};
      rx_prev_reg <= rx_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  rx_state_t        rx_state_reg, rx_state_next;
  logic [CNT_W-1:0] rx_cnt_reg, rx_cnt_next;
  logic [4:0]       rx_idx_reg, rx_idx_next;
  logic [31:0]      rx_shift_reg, rx_shift_next;
  logic             rx_ptype_reg, rx_ptype_next;
  logic             rx_pbit_reg, rx_pbit_next;
  logic             rx_tick;
  logic             rx_parity_ok;
  logic             reply_valid;
  logic [31:0]      reply_word;
  logic             good_frame;
  logic             bad_frame;

  assign rx_tick      = (rx_cnt_reg == BIT_LAST);
  assign rx_parity_ok = (rx_pbit_reg == (rx_ptype_reg ? ^rx_shift_reg : ~^rx_shift_reg));

  always_comb begin
    rx_state_next = rx_state_reg;
    rx_cnt_next   = rx_cnt_reg;
    rx_idx_next   = rx_idx_reg;
    rx_shift_next = rx_shift_reg;
    rx_ptype_next = rx_ptype_reg;
    rx_pbit_next  = rx_pbit_reg;
    reply_valid   = 1'b0;
    reply_word    = ERR_WORD;
    good_frame    = 1'b0;
    bad_frame     = 1'b0;

    case (rx_state_reg)
      RX_IDLE: begin
        if (start_edge) begin
          rx_state_next = RX_START;
          rx_cnt_next   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_reg == HALF_LAST) begin
          rx_cnt_next = '0;
          if (!rx_s) begin
            rx_state_next = RX_DATA;
            rx_idx_next   = 5'd0;
            rx_ptype_next = parity_type;
          end else begin
            rx_state_next = RX_IDLE;
          end
        end else begin
          rx_cnt_next = rx_cnt_reg + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_tick) begin
          rx_cnt_next   = '0;
          rx_shift_next = {rx_s, rx_shift_reg[31:1]};
          rx_idx_next   = rx_idx_reg + 5'd1;
          if (rx_idx_reg == 5'd31) begin
            rx_state_next = RX_PARITY;
          end
        end else begin
          rx_cnt_next = rx_cnt_reg + 1'b1;
        end
      end
      RX_PARITY: begin
        if (rx_tick) begin
          rx_cnt_next   = '0;
          rx_pbit_next  = rx_s;
          rx_state_next = RX_STOP;
        end else begin
          rx_cnt_next = rx_cnt_reg + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_tick) begin
          rx_cnt_next = '0;
          reply_valid = 1'b1;
          if (rx_s && rx_parity_ok) begin
            reply_word    = rx_shift_reg;
            good_frame    = 1'b1;
            rx_state_next = RX_IDLE;
          end else begin
            bad_frame     = 1'b1;
            // A low stop bit means the line may stay low; wait for it to recover.
            rx_state_next = rx_s ? RX_IDLE : RX_WAIT_HIGH;
          end
        end else begin
          rx_cnt_next = rx_cnt_reg + 1'b1;
        end
      end
      RX_WAIT_HIGH: begin
        if (rx_s) begin
          rx_state_next = RX_IDLE;
        end
      end
      default: begin
        rx_state_next = RX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_reg <= RX_IDLE;
      rx_cnt_reg   <= '0;
      rx_idx_reg   <= 5'd0;
      rx_shift_reg <= 32'd0;
      rx_ptype_reg <= 1'b0;
      rx_pbit_reg  <= 1'b0;
    end else begin
      rx_state_reg <= rx_state_next;
      rx_cnt_reg   <= rx_cnt_next;
      rx_idx_reg   <= rx_idx_next;
      rx_shift_reg <= rx_shift_next;
      rx_ptype_reg <= rx_ptype_next;
      rx_pbit_reg  <= rx_pbit_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Pending reply buffer
  // ---------------------------------------------------------------------------
  tx_state_t   tx_state_reg, tx_state_next;
  logic        pend_full_reg, pend_full_next;
  logic [31:0] pend_word_reg, pend_word_next;
  logic        tx_load;
  logic        overrun;

  assign tx_load = (tx_state_reg == TX_IDLE) && pend_full_reg && !tx_hold;

  always_comb begin
    pend_full_next = pend_full_reg;
    pend_word_next = pend_word_reg;
    overrun        = 1'b0;
    if (tx_load) begin
      pend_full_next = 1'b0;
    end
    // A reply arriving while the buffer drains into TX takes the freed slot.
    if (reply_valid) begin
      if (pend_full_reg && !tx_load) begin
        overrun = 1'b1;
      end else begin
        pend_full_next = 1'b1;
        pend_word_next = reply_word;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] tx_cnt_reg, tx_cnt_next;
  logic [4:0]       tx_idx_reg, tx_idx_next;
  logic [31:0]      tx_shift_reg, tx_shift_next;
  logic             tx_pbit_reg, tx_pbit_next;
  logic             tx_reg, tx_bit_next;
  logic             tx_tick;

  assign tx_tick = (tx_cnt_reg == BIT_LAST);

  // tx_reg follows the current state one cycle later, so every bit keeps a full period.
  always_comb begin
    tx_state_next = tx_state_reg;
    tx_cnt_next   = tx_cnt_reg;
    tx_idx_next   = tx_idx_reg;
    tx_shift_next = tx_shift_reg;
    tx_pbit_next  = tx_pbit_reg;
    tx_bit_next   = 1'b1;

    case (tx_state_reg)
      TX_IDLE: begin
        if (tx_load) begin
          tx_shift_next = pend_word_reg;
          tx_pbit_next  = parity_type ? ^pend_word_reg : ~^pend_word_reg;
          tx_cnt_next   = '0;
          tx_state_next = TX_START;
        end
      end
      TX_START: begin
        tx_bit_next = 1'b0;
        if (tx_tick) begin
          tx_cnt_next   = '0;
          tx_idx_next   = 5'd0;
          tx_state_next = TX_DATA;
        end else begin
          tx_cnt_next = tx_cnt_reg + 1'b1;
        end
      end
      TX_DATA: begin
        tx_bit_next = tx_shift_reg[0];
        if (tx_tick) begin
          tx_cnt_next   = '0;
          tx_shift_next = {1'b0, tx_shift_reg[31:1]};
          tx_idx_next   = tx_idx_reg + 5'd1;
          if (tx_idx_reg == 5'd31) begin
            tx_state_next = TX_PARITY;
          end
        end else begin
          tx_cnt_next = tx_cnt_reg + 1'b1;
        end
      end
      TX_PARITY: begin
        tx_bit_next = tx_pbit_reg;
        if (tx_tick) begin
          tx_cnt_next   = '0;
          tx_state_next = TX_STOP;
        end else begin
          tx_cnt_next = tx_cnt_reg + 1'b1;
        end
      end
      TX_STOP: begin
        tx_bit_next = 1'b1;
        if (tx_tick) begin
          tx_cnt_next   = '0;
          tx_state_next = TX_IDLE;
        end else begin
          tx_cnt_next = tx_cnt_reg + 1'b1;
        end
      end
      default: begin
        tx_state_next = TX_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Saturating counters
  // ---------------------------------------------------------------------------
  logic [15:0] frame_count_reg, frame_count_next;
  logic [15:0] err_count_reg, err_count_next;
  logic [7:0]  overrun_count_reg, overrun_count_next;
  logic        busy_reg;

  always_comb begin
    frame_count_next   = frame_count_reg;
    err_count_next     = err_count_reg;
    overrun_count_next = overrun_count_reg;
    if (good_frame && (frame_count_reg != 16'hFFFF)) begin
      frame_count_next = frame_count_reg + 16'd1;
    end
    if (bad_frame && (err_count_reg != 16'hFFFF)) begin
      err_count_next = err_count_reg + 16'd1;
    end
    if (overrun && (overrun_count_reg != 8'hFF)) begin
      overrun_count_next = overrun_count_reg + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_full_reg     <= 1'b0;
      pend_word_reg     <= 32'd0;
      tx_state_reg      <= TX_IDLE;
      tx_cnt_reg        <= '0;
      tx_idx_reg        <= 5'd0;
      tx_shift_reg      <= 32'd0;
      tx_pbit_reg       <= 1'b0;
      tx_reg            <= 1'b1;
      busy_reg          <= 1'b0;
      frame_count_reg   <= 16'd0;
      err_count_reg     <= 16'd0;
      overrun_count_reg <= 8'd0;
    end else begin
      pend_full_reg     <= pend_full_next;
      pend_word_reg     <= pend_word_next;
      tx_state_reg      <= tx_state_next;
      tx_cnt_reg        <= tx_cnt_next;
      tx_idx_reg        <= tx_idx_next;
      tx_shift_reg      <= tx_shift_next;
      tx_pbit_reg       <= tx_pbit_next;
      tx_reg            <= tx_bit_next;
      busy_reg          <= (tx_state_next != TX_IDLE) || pend_full_next;
      frame_count_reg   <= frame_count_next;
      err_count_reg     <= err_count_next;
      overrun_count_reg <= overrun_count_next;
    end
  end

  assign tx            = tx_reg;
  assign busy          = busy_reg;
  assign frame_count   = frame_count_reg;
  assign err_count     = err_count_reg;
  assign overrun_count = overrun_count_reg;

endmodule

// File: tb/tb_uart_echo_responder.sv
// Directed bench for uart_echo_responder: frames are driven on rx, expected replies are
// queued at drive time and compared when the tx monitor decodes them.
module tb_uart_echo_responder;

  localparam int          N   = 16;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  typedef struct packed {
    logic [31:0] data;
    logic        par;
  } reply_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx = 1'b0;
  logic        parity_type = 1'b0;
  logic        tx_hold = 1'b0;
  logic        tx;
  logic        busy;
  logic [15:0] frame_count;
  logic [15:0] err_count;
  logic [7:0]  overrun_count;

  int     n_checks = 0;
  int     n_errors = 0;
  int     rst_epoch = 0;
  logic   mon_busy = 1'b0;
  reply_t sb[$];

  uart_echo_responder #(.CLKS_PER_BIT(N), .ERR_WORD(ERR)) dut (
    .clk(clk), .rst(rst), .rx(rx), .parity_type(parity_type), .tx_hold(tx_hold),
    .tx(tx), .busy(busy), .frame_count(frame_count), .err_count(err_count),
    .overrun_count(overrun_count)
  );

  always #5 clk = ~clk;

  function automatic logic par_of(input logic [31:0] d, input logic ptype);
    return ptype ? ^d : ~^d;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_reply(input logic [31:0] d);
    sb.push_back({d, par_of(d, parity_type)});
  endtask

  // Drives one frame bit-aligned to clk; optionally checks the tx start-bit latency.
  task automatic send_frame(input logic [31:0] d, input logic pbit, input logic sbit,
                            input bit chk_lat);
    logic [34:0] bits;
    int          cyc;
    bits = {sbit, pbit, d, 1'b0};
    @(posedge clk);
    #1;
    cyc = 0;
    $display("drive  data=%08h par=%0b stop=%0b", d, pbit, sbit);
    for (int b = 0; b < 35; b++) begin
      rx = bits[b];
      for (int k = 0; k < N; k++) begin
        @(posedge clk);
        #1;
        cyc++;
        if (chk_lat && cyc == 34 * N + N / 2 + 4) check("tx_before_fall", tx, 1);
        if (chk_lat && cyc == 34 * N + N / 2 + 5) check("tx_fall_latency", tx, 0);
      end
    end
  endtask

  task automatic wait_drain(input string tag);
    int  n;
    bit  done;
    n    = 0;
    done = 0;
    while (!done && n < 60 * N) begin
      if (sb.size() == 0 && !mon_busy && !busy) done = 1;
      else begin
        tick(1);
        n++;
      end
    end
    check(tag, done, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rst_epoch++;
    sb.delete();
    tick(2);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_counts", {frame_count, err_count, overrun_count}, 0);
    @(negedge clk);
    rst = 1'b0;
    tick(2);
  endtask

  // tx monitor: decodes each reply frame at mid-bit and checks it against the scoreboard.
  initial begin : monitor
    logic [34:0] bits;
    int          ep;
    bit          aborted;
    reply_t      e;
    forever begin
      @(negedge tx);
      if (!rst) begin
        mon_busy = 1'b1;
        ep       = rst_epoch;
        aborted  = 0;
        bits     = '0;
        repeat (N / 2) @(posedge clk);
        #1;
        for (int b = 0; b < 35; b++) begin
          if (b > 0) begin
            repeat (N) @(posedge clk);
            #1;
          end
          if (rst || rst_epoch != ep) begin
            aborted = 1;
            break;
          end
          bits[b] = tx;
        end
        if (!aborted) begin
          $display("reply  data=%08h par=%0b stop=%0b", bits[32:1], bits[33], bits[34]);
          check("reply_expected", sb.size() > 0, 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check("reply_start", bits[0], 0);
            check("reply_data", bits[32:1], e.data);
            check("reply_parity", bits[33], e.par);
            check("reply_stop", bits[34], 1);
          end
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #(90000 * 10);
    $display("FAIL watchdog: simulation exceeded its cycle budget");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    // Reset with the line already low: no start may be taken without a high-to-low edge.
    rst = 1'b1;
    rx  = 1'b0;
    tick(3);
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_frame_count", frame_count, 0);
    check("reset_err_count", err_count, 0);
    check("reset_overrun_count", overrun_count, 0);
    @(negedge clk);
    rst = 1'b0;
    tick(2 * N);
    rx = 1'b1;
    tick(40 * N);
    check("low_line_frame_count", frame_count, 0);
    check("low_line_err_count", err_count, 0);
    check("low_line_busy", busy, 0);

    // Odd parity echo with latency check.
    parity_type = 1'b0;
    expect_reply(32'hA5A5A5A5);
    send_frame(32'hA5A5A5A5, 1'b1, 1'b1, 1);
    check("odd_frame_count", frame_count, 1);
    wait_drain("odd_drain");
    check("odd_err_count", err_count, 0);

    // Even parity echo.
    do_reset();
    parity_type = 1'b1;
    expect_reply(32'h12345678);
    send_frame(32'h12345678, 1'b1, 1'b1, 0);
    wait_drain("even_drain");
    check("even_frame_count", frame_count, 1);
    check("even_err_count", err_count, 0);

    // Parity error yields ERR_WORD.
    do_reset();
    parity_type = 1'b0;
    expect_reply(ERR);
    send_frame(32'hA5A5A5A5, 1'b0, 1'b1, 0);
    wait_drain("parerr_drain");
    check("parerr_err_count", err_count, 1);
    check("parerr_frame_count", frame_count, 0);

    // Short low glitch is not a frame.
    rx = 1'b0;
    tick(2);
    rx = 1'b1;
    tick(3 * N);
    check("glitch_frame_count", frame_count, 0);
    check("glitch_err_count", err_count, 1);
    check("glitch_busy", busy, 0);

    // Framing error with the line held low afterwards.
    do_reset();
    expect_reply(ERR);
    send_frame(32'hA5A5A5A5, 1'b1, 1'b0, 0);
    tick(5 * N);
    check("frmerr_err_count_low", err_count, 1);
    check("frmerr_frame_count_low", frame_count, 0);
    rx = 1'b1;
    wait_drain("frmerr_drain");
    check("frmerr_err_count", err_count, 1);
    expect_reply(32'h0F0F1E1E);
    send_frame(32'h0F0F1E1E, par_of(32'h0F0F1E1E, 1'b0), 1'b1, 0);
    wait_drain("frmerr_recover_drain");
    check("frmerr_recover_frame_count", frame_count, 1);

    // tx_hold with three frames: only the first survives.
    do_reset();
    tx_hold = 1'b1;
    expect_reply(32'h11111111);
    send_frame(32'h11111111, par_of(32'h11111111, 1'b0), 1'b1, 0);
    send_frame(32'h22222222, par_of(32'h22222222, 1'b0), 1'b1, 0);
    send_frame(32'h33333333, par_of(32'h33333333, 1'b0), 1'b1, 0);
    tick(2 * N);
    check("hold_busy", busy, 1);
    check("hold_tx", tx, 1);
    check("hold_overrun_count", overrun_count, 2);
    check("hold_frame_count", frame_count, 3);
    check("hold_pending_replies", sb.size(), 1);
    tx_hold = 1'b0;
    wait_drain("hold_drain");
    check("hold_overrun_after", overrun_count, 2);

    // Reset in the middle of data bit 10 of a reply.
    do_reset();
    parity_type = 1'b1;
    expect_reply(32'h5A5AC3C3);
    send_frame(32'h5A5AC3C3, par_of(32'h5A5AC3C3, 1'b1), 1'b1, 0);
    tick(11 * N + 5);
    check("midreply_tx_bit10", tx, 0);
    check("midreply_busy", busy, 1);
    @(negedge clk);
    rst = 1'b1;
    rst_epoch++;
    sb.delete();
    #1;
    check("midreply_rst_tx", tx, 1);
    check("midreply_rst_busy", busy, 0);
    check("midreply_rst_counts", {frame_count, err_count, overrun_count}, 0);
    tick(3);
    @(negedge clk);
    rst = 1'b0;
    tick(2);
    expect_reply(32'hCAFEF00D);
    send_frame(32'hCAFEF00D, par_of(32'hCAFEF00D, 1'b1), 1'b1, 0);
    wait_drain("post_rst_drain");
    check("post_rst_frame_count", frame_count, 1);
    check("post_rst_err_count", err_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
